// File: rtl/frame_uart_sender.sv
// frame_uart_sender: streams one stored image over a byte-wide UART
// transmitter as a single packet (sync byte, then pixels in raster order).
// Reads a synchronous pixel memory with one cycle of read latency.
//
// Byte handshake: a byte moves on every uart_clk edge where
// tx_valid && tx_ready; once tx_valid rises, tx_valid and tx_data hold
// until that transfer, and tx_ready may be high before tx_valid.
module frame_uart_sender #(
  parameter int         WIDTH     = 534,
  parameter int         HEIGHT    = 400,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  localparam int        MEM_DEPTH = WIDTH * HEIGHT,
  localparam int        AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic          uart_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [7:0]    rd_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    READ = 3'd2,
    CAPT = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } state_t;

  // Current state is kept as a named signal so it can be probed directly.
  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] rd_addr_nx;
  logic          rd_en_nx;
  logic [7:0]    tx_data_nx;
  logic          tx_valid_nx;
  logic          busy_nx;
  logic          done_nx;
  logic          xfer;

  assign xfer = tx_valid & tx_ready;

  // State and all outputs are registered together.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_addr  <= rd_addr_nx;
      rd_en    <= rd_en_nx;
      tx_data  <= tx_data_nx;
      tx_valid <= tx_valid_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_nx    = state;
    rd_addr_nx  = rd_addr;
    rd_en_nx    = rd_en;
    tx_data_nx  = tx_data;
    tx_valid_nx = tx_valid;
    busy_nx     = busy;
    done_nx     = done;

    case (state)
      IDLE: begin
        // abort together with start keeps the block idle
        if (start && !abort) begin
          tx_data_nx  = SYNC_BYTE;
          tx_valid_nx = 1'b1;
          rd_addr_nx  = '0;
          busy_nx     = 1'b1;
          state_nx    = SYNC;
        end
      end
      SYNC: begin
        if (xfer) begin
          tx_valid_nx = 1'b0;
          rd_en_nx    = 1'b1;
          state_nx    = READ;
        end
      end
      READ: begin
        // read strobe lasts exactly one cycle; data arrives in CAPT
        rd_en_nx = 1'b0;
        state_nx = CAPT;
      end
      CAPT: begin
        tx_data_nx  = rd_data;
        tx_valid_nx = 1'b1;
        state_nx    = SEND;
      end
      SEND: begin
        if (xfer) begin
          tx_valid_nx = 1'b0;
          if (rd_addr == LAST_ADDR) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = DONE;
          end else begin
            rd_addr_nx = rd_addr + 1'b1;
            rd_en_nx   = 1'b1;
            state_nx   = READ;
          end
        end
      end
      DONE: begin
        done_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Cancel: a byte handshaken this same cycle has already gone out.
    if (abort && (state != IDLE)) begin
      state_nx    = IDLE;
      tx_valid_nx = 1'b0;
      rd_en_nx    = 1'b0;
      busy_nx     = 1'b0;
      done_nx     = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_uart_sender.sv
// Directed bench for frame_uart_sender with a 4x2 image (addresses 0..7).
module tb_frame_uart_sender;

  localparam int AW = 3;

  logic          uart_clk = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [7:0]    rd_data  = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] mem [0:7];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt  = 0;
  int         hold_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       rand_ready = 1'b0;

  frame_uart_sender #(.WIDTH(4), .HEIGHT(2), .SYNC_BYTE(8'hAA)) dut (
    .uart_clk(uart_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // clock / reset block
  always #5 uart_clk = ~uart_clk;

  // synchronous-read pixel memory, one cycle latency
  always @(posedge uart_clk) if (rd_en) rd_data <= mem[rd_addr];

  // pseudo-random ready when enabled
  always @(posedge uart_clk) if (rand_ready) begin
    #1;
    tx_ready = ($urandom_range(0, 99) < 45);
  end

  // byte log: a transfer happens at the next posedge when valid&&ready here
  always @(negedge uart_clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      if (prev_stall && (!tx_valid || tx_data != prev_data)) hold_viol++;
      prev_stall = tx_valid && !tx_ready && !abort;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge uart_clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    done_cnt  = 0;
    hold_viol = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_mem(input logic sync_at_2);
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    if (sync_at_2) mem[2] = 8'hAA;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic wait_done(input int budget, output int n, output bit seen,
                           output bit busy_drop);
    n = 0; seen = 0; busy_drop = 0;
    while (!seen && n < budget) begin
      @(negedge uart_clk);
      n++;
      if (done) seen = 1;
      else if (!busy) busy_drop = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    @(negedge uart_clk);
    n_vec++; if (rd_addr !== 3'd0) begin n_miss++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
    n_vec++; if (rd_en !== 1'b0) begin n_miss++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    n_vec++; if (tx_data !== 8'h00) begin n_miss++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
    n_vec++; if (tx_valid !== 1'b0) begin n_miss++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b expected 0", done); end
    tick();
  endtask

  task automatic test_basic_frame();
    int n; bit seen; bit drop;
    load_mem(1'b0);
    tx_ready = 1'b1;
    clear_log();
    pulse_start();                       // start sampled at edge 0
    @(negedge uart_clk);                 // cycle 1
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA || busy !== 1'b1) begin
      n_miss++; $display("FAIL basic_sync_cycle1: got v=%b d=%0h b=%b expected v=1 d=aa b=1", tx_valid, tx_data, busy);
    end
    tick();
    @(negedge uart_clk);                 // cycle 2: read strobe
    n_vec++; if (rd_en !== 1'b1 || tx_valid !== 1'b0 || rd_addr !== 3'd0) begin
      n_miss++; $display("FAIL basic_read_cycle2: got en=%b v=%b a=%0d expected en=1 v=0 a=0", rd_en, tx_valid, rd_addr);
    end
    tick();
    @(negedge uart_clk);                 // cycle 3: capture
    n_vec++; if (rd_en !== 1'b0 || tx_valid !== 1'b0) begin
      n_miss++; $display("FAIL basic_capt_cycle3: got en=%b v=%b expected en=0 v=0", rd_en, tx_valid);
    end
    tick();
    @(negedge uart_clk);                 // cycle 4: pixel 0 offered
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin
      n_miss++; $display("FAIL basic_pix0_cycle4: got v=%b d=%0h expected v=1 d=10", tx_valid, tx_data);
    end
    wait_done(100, n, seen, drop);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL basic_done_timeout: got no done expected done"); end
    n_vec++; if (n + 4 !== 26) begin n_miss++; $display("FAIL basic_done_cycle: got %0d expected 26", n + 4); end
    n_vec++; if (drop) begin n_miss++; $display("FAIL basic_busy_held: got busy low mid-frame expected high"); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    tick();
    @(negedge uart_clk);
    n_vec++; if (done !== 1'b0 || rd_addr !== 3'd7) begin
      n_miss++; $display("FAIL basic_after_done: got done=%b a=%0d expected done=0 a=7", done, rd_addr);
    end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    n_vec++; if (got_q.size() !== 9) begin n_miss++; $display("FAIL basic_byte_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL basic_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  task automatic test_ready_toggle();
    int n; bit seen; bit drop;
    load_mem(1'b0);
    clear_log();
    rand_ready = 1'b1;
    pulse_start();
    wait_done(600, n, seen, drop);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL toggle_done_timeout: got no done expected done"); end
    tick();
    rand_ready = 1'b0;
    #2;
    tx_ready = 1'b1;
    n_vec++; if (hold_viol !== 0) begin n_miss++; $display("FAIL toggle_hold: got %0d changes under stall expected 0", hold_viol); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL toggle_done_count: got %0d expected 1", done_cnt); end
    n_vec++; if (got_q.size() !== 9) begin n_miss++; $display("FAIL toggle_byte_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL toggle_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  task automatic test_start_spam();
    load_mem(1'b0);
    tx_ready = 1'b1;
    clear_log();
    pulse_start();                       // edge 0
    // value driven here is sampled at edge e; edge 26 is the DONE cycle
    for (int e = 1; e <= 40; e++) begin
      start = ((e % 4 == 0) && (e <= 24)) || (e == 26);
      tick();
    end
    start = 1'b0;
    tick();
    @(negedge uart_clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL spam_busy_end: got %b expected 0", busy); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL spam_done_count: got %0d expected 1", done_cnt); end
    n_vec++; if (got_q.size() !== 9) begin n_miss++; $display("FAIL spam_byte_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL spam_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  task automatic test_abort();
    int n; bit seen; bit drop;
    load_mem(1'b0);
    tx_ready = 1'b1;
    clear_log();
    pulse_start();                       // edge 0
    repeat (12) tick();                  // after edge 12: 0x13 offered
    tx_ready = 1'b0;
    @(negedge uart_clk);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h13) begin
      n_miss++; $display("FAIL abort_pending: got v=%b d=%0h expected v=1 d=13", tx_valid, tx_data);
    end
    tick();                              // edge 13, no transfer
    abort = 1'b1;
    tick();                              // edge 14 cancels
    abort = 1'b0;
    @(negedge uart_clk);
    n_vec++; if (tx_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
      n_miss++; $display("FAIL abort_idle: got v=%b b=%b en=%b done=%b expected all 0", tx_valid, busy, rd_en, done);
    end
    repeat (5) tick();
    n_vec++; if (done_cnt !== 0) begin n_miss++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    n_vec++; if (got_q.size() !== 4) begin n_miss++; $display("FAIL abort_partial_count: got %0d expected 4", got_q.size()); end
    // abort and start together in IDLE: stays idle
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge uart_clk);
    n_vec++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_miss++; $display("FAIL abort_start_idle: got b=%b v=%b expected b=0 v=0", busy, tx_valid);
    end
    tick();
    tx_ready = 1'b1;
    clear_log();
    pulse_start();
    wait_done(100, n, seen, drop);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL abort_restart_timeout: got no done expected done"); end
    tick();
    n_vec++; if (got_q.size() !== 9) begin n_miss++; $display("FAIL abort_restart_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL abort_restart_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    int n; bit seen; bit drop;
    load_mem(1'b0);
    tx_ready = 1'b1;
    clear_log();
    pulse_start();                       // edge 0
    tick();                              // after edge 1: READ
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (rd_en !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00 || rd_addr !== 3'd0) begin
      n_miss++; $display("FAIL rst_async: got en=%b v=%b b=%b done=%b d=%0h a=%0d expected all 0",
                         rd_en, tx_valid, busy, done, tx_data, rd_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    pulse_start();
    wait_done(100, n, seen, drop);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL rst_restart_timeout: got no done expected done"); end
    tick();
    n_vec++; if (got_q.size() !== 9) begin n_miss++; $display("FAIL rst_restart_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL rst_restart_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  task automatic test_sync_pixel();
    int n; bit seen; bit drop;
    load_mem(1'b1);                      // expected: aa 10 11 aa 13 14 15 16 17
    tx_ready = 1'b1;
    clear_log();
    pulse_start();
    wait_done(100, n, seen, drop);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL syncpix_timeout: got no done expected done"); end
    tick();
    n_vec++; if (got_q.size() !== 9) begin n_miss++; $display("FAIL syncpix_count: got %0d expected 9", got_q.size()); end
    n_vec++; if (got_q.size() > 3 && got_q[3] !== 8'hAA) begin n_miss++; $display("FAIL syncpix_byte3: got %0h expected aa", got_q[3]); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL syncpix_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ready_toggle();
    test_start_spam();
    test_abort();
    test_reset_mid_read();
    test_sync_pixel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/frame_uart_sender.md
# frame_uart_sender

- Streams a stored image out over UART as one packet: sync byte, then `WIDTH*HEIGHT` pixel bytes in raster order.
- This is the return-path counterpart of the UART-loaded frame buffer. A host can read back a captured or edge-processed frame in the same format it uses to load one.
- Sits between a synchronous-read pixel memory port (1-cycle read latency) and a byte-wide UART transmitter with a valid/ready handshake.
- Runs entirely in the `uart_clk` domain.

## Interface

Parameters:
- `WIDTH`, 534: image width in pixels.
- `HEIGHT`, 400: image height in pixels.
- `SYNC_BYTE`, 8'hAA: packet header byte, sent before pixel 0.

Derived values:
- `MEM_DEPTH = WIDTH*HEIGHT`.
- `AW = $clog2(MEM_DEPTH)`.

Ports:
- `uart_clk`  in  1: the only clock; all logic on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: single-cycle request to send one frame; ignored while `busy`.
- `abort`  in  1: synchronous cancel of a transfer in progress.
- `rd_addr`  out  AW: memory read address.
- `rd_en`  out  1: memory read strobe.
- `rd_data`  in  8: memory read data, valid the cycle after the `rd_en` cycle.
- `tx_data`  out  8: byte to the UART transmitter.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: transmitter accepts a byte.
- `busy`  out  1: a transfer is in progress.
- `done`  out  1: one-cycle pulse after the last pixel is accepted.

## Operation

- All outputs are registered.
- Reset values: `rd_addr=0`, `rd_en=0`, `tx_data=0`, `tx_valid=0`, `busy=0`, `done=0`, state `IDLE`.
- Handshake: a byte transfers on a cycle where `tx_valid && tx_ready`.
  - Once `tx_valid` rises, `tx_valid` and `tx_data` hold until that transfer.
  - `tx_ready` may be high before `tx_valid`.

States:
- `IDLE`: `busy=0`. On `start`: `tx_data<=SYNC_BYTE`, `tx_valid<=1`, `rd_addr<=0`, `busy<=1`, go to `SYNC`.
- `SYNC`: on transfer: `tx_valid<=0`, `rd_en<=1`, go to `READ`.
- `READ`: `rd_en` is high for exactly this cycle; `rd_en<=0`, go to `CAPT`.
- `CAPT`: `tx_data<=rd_data`, `tx_valid<=1`, go to `SEND`.
- `SEND`: on transfer, `tx_valid<=0`, then:
  - if `rd_addr==MEM_DEPTH-1`: go to `DONE`, `done<=1`, `busy<=0`;
  - otherwise: `rd_addr<=rd_addr+1`, `rd_en<=1`, go to `READ`.
- `DONE`: `done<=0`, go to `IDLE`. `rd_addr` stays at `MEM_DEPTH-1` until the next `start`.

Address rules:
- `rd_addr` never exceeds `MEM_DEPTH-1`.
- Addresses are issued strictly in increments of 1 from 0.
- Each address is read exactly once per frame.

Boundary conditions:
- `start` while `busy`, or in the `DONE` cycle: ignored; no queuing.
- `abort` in any state other than `IDLE`: next edge forces `IDLE`, with `tx_valid=0`, `rd_en=0`, `busy=0`.
  - No `done` pulse.
  - A byte already handshaken in that same cycle counts as sent.
- `abort` and `start` together in `IDLE`: `abort` wins; stay in `IDLE`.
- `tx_ready` stuck low: the block waits indefinitely in `SYNC` or `SEND`, with no timeout.
- `rst_n` low mid-frame: immediate return to reset values. The next `start` restarts from the sync byte.
- A pixel value equal to `SYNC_BYTE` is sent as ordinary data; there is no escaping.

## Timing

- Take `start` as high at edge 0. Then `tx_valid=1` with `SYNC_BYTE` from cycle 1.
- If the sync byte transfers at edge k:
  - `rd_en` is high in cycle k+1;
  - `tx_valid` carries pixel 0 from cycle k+3.
- Pixel-to-pixel gap:
  - 3 cycles minimum from one transfer edge to the next `tx_valid` rise;
  - with `tx_ready` tied high, one byte per 3 cycles.
- `done` is high in the cycle after the last transfer edge, and `busy` falls at that same edge.
- Total bytes per frame: `MEM_DEPTH+1`.

## Test plan

- Reset, then `WIDTH=4`, `HEIGHT=2`, memory holding 0x10..0x17, `tx_ready=1`, pulse `start`:
  - output is exactly 0xAA, 0x10, ..., 0x17 (9 bytes);
  - `done` pulses once; `busy` is high throughout the frame.
- Same setup, `tx_ready` toggling pseudo-randomly:
  - identical byte sequence;
  - `tx_data` and `tx_valid` never change while `tx_valid=1` and `tx_ready=0`.
- `start` pulsed repeatedly mid-frame: exactly one packet of 9 bytes; no restart.
- `abort` while byte 0x13 is pending (not yet accepted):
  - `tx_valid=0` next cycle, no `done`;
  - a later `start` yields 0xAA, 0x10, ... from address 0.
- `rst_n` low asynchronously mid-`READ`: all outputs read their reset values before the next clock edge; `rd_en=0`.
- Pixel memory containing 0xAA at address 2: sent verbatim as the 4th byte; total count is still 9.
